// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned CNT_W     = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with registered edge, START and STOP detection.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_cur;
    logic                   sda_cur;
    logic                   scl_prev;
    logic                   sda_prev;

    assign scl_cur = scl_sync[SYNC_STAGES-1];
    assign sda_cur = sda_sync[SYNC_STAGES-1];

    // Chains reset to the idle-bus level so reset release raises no events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda       <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev  <= scl_cur;
            sda_prev  <= sda_cur;
            scl_rise  <= scl_cur & ~scl_prev;
            scl_fall  <= ~scl_cur & scl_prev;
            start_det <= scl_cur & scl_prev & sda_prev & ~sda_cur;
            stop_det  <= scl_cur & scl_prev & ~sda_prev & sda_cur;
            sda       <= sda_cur;
        end
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target bridging bus transactions onto a single-cycle 8-bit register port.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addr_hit
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda      (sda)
    );

    i2c_tgt_state_t   state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]       rx, rx_nxt;
    logic [7:0]       tx, tx_nxt;
    logic             rw, rw_nxt;
    logic             ack_bit, ack_bit_nxt;
    logic             load_pend, load_pend_nxt;
    logic             sda_oe_nxt;
    logic [7:0]       reg_addr_nxt;
    logic [7:0]       reg_wdata_nxt;
    logic             reg_we_nxt;
    logic             reg_re_nxt;
    logic             busy_nxt;
    logic             addr_hit_nxt;
    logic             byte_done;

    assign byte_done = (bit_cnt == CNT_W'(BYTE_BITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            ack_bit   <= NACK;
            load_pend <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx        <= rx_nxt;
            tx        <= tx_nxt;
            rw        <= rw_nxt;
            ack_bit   <= ack_bit_nxt;
            load_pend <= load_pend_nxt;
            sda_oe    <= sda_oe_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            reg_we    <= reg_we_nxt;
            reg_re    <= reg_re_nxt;
            busy      <= busy_nxt;
            addr_hit  <= addr_hit_nxt;
        end
    end

    // Bus FSM: sample on SCL rise, act and change SDA on SCL fall.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        rx_nxt        = rx;
        tx_nxt        = tx;
        rw_nxt        = rw;
        ack_bit_nxt   = ack_bit;
        load_pend_nxt = reg_re;
        sda_oe_nxt    = sda_oe;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        reg_we_nxt    = 1'b0;
        reg_re_nxt    = 1'b0;
        busy_nxt      = busy;
        addr_hit_nxt  = 1'b0;

        // Pointer advances the cycle after a write strobe.
        if (reg_we) begin
            reg_addr_nxt = reg_addr + 8'd1;
        end

        if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
        end else begin
            if (scl_rise) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        rx_nxt      = {rx[6:0], sda};
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                    RDATA:     bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    RDATA_ACK: ack_bit_nxt = sda;
                    default: ;
                endcase
            end

            if (scl_fall) begin
                case (state)
                    ADDR: begin
                        if (byte_done) begin
                            bit_cnt_nxt = '0;
                            if (rx[7:1] == DEV_ADDR) begin
                                state_nxt    = ADDR_ACK;
                                rw_nxt       = rx[0];
                                sda_oe_nxt   = 1'b1;
                                addr_hit_nxt = 1'b1;
                                busy_nxt     = 1'b1;
                            end else begin
                                state_nxt  = IGNORE;
                                sda_oe_nxt = 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        sda_oe_nxt = 1'b0;
                        if (rw) begin
                            reg_re_nxt = 1'b1;
                            state_nxt  = RDATA;
                        end else begin
                            state_nxt = PTR;
                        end
                    end
                    PTR: begin
                        if (byte_done) begin
                            bit_cnt_nxt  = '0;
                            reg_addr_nxt = rx;
                            sda_oe_nxt   = 1'b1;
                            state_nxt    = PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WDATA;
                    end
                    WDATA: begin
                        if (byte_done) begin
                            bit_cnt_nxt   = '0;
                            reg_wdata_nxt = rx;
                            reg_we_nxt    = 1'b1;
                            sda_oe_nxt    = 1'b1;
                            state_nxt     = WDATA_ACK;
                        end
                    end
                    WDATA_ACK: begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WDATA;
                    end
                    RDATA: begin
                        if (byte_done) begin
                            bit_cnt_nxt = '0;
                            sda_oe_nxt  = 1'b0;
                            state_nxt   = RDATA_ACK;
                        end else if (bit_cnt != '0) begin
                            tx_nxt     = tx << 1;
                            sda_oe_nxt = ~tx[6];
                        end
                    end
                    RDATA_ACK: begin
                        sda_oe_nxt = 1'b0;
                        if (ack_bit == ACK) begin
                            reg_addr_nxt = reg_addr + 8'd1;
                            reg_re_nxt   = 1'b1;
                            state_nxt    = RDATA;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                    default: ;
                endcase
            end

            // Read data arrives the cycle after reg_re; present its MSB at once.
            if (load_pend && (state == RDATA)) begin
                tx_nxt     = reg_rdata;
                sda_oe_nxt = ~reg_rdata[7];
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target with a queue-based register-port scoreboard.
module tb_i2c_reg_target;

    localparam int unsigned Q = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       addr_hit;

    int errors = 0;
    int checks = 0;

    logic [15:0] q_we[$];
    logic [7:0]  q_re[$];
    int          pending_hit = 0;
    logic        quiet = 1'b0;
    logic        quiet_viol = 1'b0;

    always #5 clk = ~clk;

    assign sda_in = m_sda & ~sda_oe;

    i2c_reg_target #(
        .DEV_ADDR   (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        case (a)
            8'h20:   return 8'h5A;
            8'h21:   return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    // Register bank model: read data valid the cycle after reg_re.
    always @(posedge clk or posedge rst) begin
        if (rst) reg_rdata <= 8'h00;
        else if (reg_re) reg_rdata <= rd_model(reg_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start;
        m_sda = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b;    wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        s = sda_in;   wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d;

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;

        fork
            begin : monitor
                logic [15:0] e16;
                logic [7:0]  e8;
                forever begin
                    @(negedge clk);
                    if (quiet && sda_oe) quiet_viol = 1'b1;
                    if (reg_we) begin
                        if (q_we.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h, expected no write", reg_addr, reg_wdata);
                        end else begin
                            e16 = q_we.pop_front();
                            check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(e16));
                            check("we_re_excl", 32'(reg_re), 32'(0));
                        end
                    end
                    if (reg_re) begin
                        if (q_re.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_re: got addr 0x%0h, expected no read", reg_addr);
                        end else begin
                            e8 = q_re.pop_front();
                            check("re_addr", 32'(reg_addr), 32'(e8));
                        end
                    end
                    if (addr_hit) begin
                        if (pending_hit == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_hit: got addr_hit=1, expected 0");
                        end else begin
                            pending_hit--;
                            check("hit_ack_busy", 32'({sda_oe, busy}), 32'(2'b11));
                        end
                    end
                end
            end
        join_none

        // Reset state
        wait_clk(3);
        check("rst_sda_oe", 32'(sda_oe), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_reg_addr", 32'(reg_addr), 32'(0));
        check("rst_reg_wdata", 32'(reg_wdata), 32'(0));
        check("rst_strobes", 32'({reg_we, reg_re, addr_hit}), 32'(0));
        rst = 1'b0;
        wait_clk(Q);

        // Single write
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("wr_addr_ack", 32'(a), 32'(0));
        check("wr_busy", 32'(busy), 32'(1));
        write_byte(8'h10, a); check("wr_ptr_ack", 32'(a), 32'(0));
        q_we.push_back({8'h10, 8'h3C});
        write_byte(8'h3C, a); check("wr_data_ack", 32'(a), 32'(0));
        bus_stop;
        wait_clk(Q);
        check("wr_busy_after_stop", 32'(busy), 32'(0));
        check("wr_addr_after", 32'(reg_addr), 32'(8'h11));

        // Burst write across the 8'hFF wrap
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("bw_addr_ack", 32'(a), 32'(0));
        write_byte(8'hFE, a); check("bw_ptr_ack", 32'(a), 32'(0));
        q_we.push_back({8'hFE, 8'h11});
        write_byte(8'h11, a); check("bw_d0_ack", 32'(a), 32'(0));
        q_we.push_back({8'hFF, 8'h22});
        write_byte(8'h22, a); check("bw_d1_ack", 32'(a), 32'(0));
        q_we.push_back({8'h00, 8'h33});
        write_byte(8'h33, a); check("bw_d2_ack", 32'(a), 32'(0));
        bus_stop;
        wait_clk(Q);
        check("bw_final_addr", 32'(reg_addr), 32'(8'h01));

        // Combined write-pointer / repeated-START read
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("rd_waddr_ack", 32'(a), 32'(0));
        write_byte(8'h20, a); check("rd_ptr_ack", 32'(a), 32'(0));
        bus_start;
        pending_hit++;
        q_re.push_back(8'h20);
        write_byte(8'hA1, a); check("rd_raddr_ack", 32'(a), 32'(0));
        q_re.push_back(8'h21);
        read_byte(1'b0, d); check("rd_byte0", 32'(d), 32'(8'h5A));
        read_byte(1'b1, d); check("rd_byte1", 32'(d), 32'(8'hC3));
        check("rd_release_after_nack", 32'(sda_oe), 32'(0));
        bus_stop;
        wait_clk(Q);
        check("rd_busy_after_stop", 32'(busy), 32'(0));
        check("rd_final_addr", 32'(reg_addr), 32'(8'h21));

        // Foreign address must leave the bus untouched
        quiet = 1'b1;
        bus_start;
        write_byte(8'hA2, a); check("mm_addr_nack", 32'(a), 32'(1));
        write_byte(8'h55, a); check("mm_data_nack", 32'(a), 32'(1));
        bus_stop;
        wait_clk(Q);
        quiet = 1'b0;
        check("mm_oe_quiet", 32'(quiet_viol), 32'(0));
        check("mm_busy", 32'(busy), 32'(0));

        // STOP after four data bits aborts the write
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("ab_addr_ack", 32'(a), 32'(0));
        write_byte(8'h40, a); check("ab_ptr_ack", 32'(a), 32'(0));
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        bus_stop;
        wait_clk(Q);
        check("ab_busy", 32'(busy), 32'(0));
        check("ab_addr_kept", 32'(reg_addr), 32'(8'h40));
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("ab_next_ack", 32'(a), 32'(0));
        write_byte(8'h41, a); check("ab_next_ptr_ack", 32'(a), 32'(0));
        bus_stop;
        wait_clk(Q);
        check("ab_next_addr", 32'(reg_addr), 32'(8'h41));

        // Asynchronous reset in the middle of a read byte
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("rr_waddr_ack", 32'(a), 32'(0));
        write_byte(8'h30, a); check("rr_ptr_ack", 32'(a), 32'(0));
        bus_start;
        pending_hit++;
        q_re.push_back(8'h30);
        write_byte(8'hA1, a); check("rr_raddr_ack", 32'(a), 32'(0));
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        check("rr_driving_zero", 32'(sda_oe), 32'(1));
        rst = 1'b1;
        #1;
        check("rr_async_oe", 32'(sda_oe), 32'(0));
        check("rr_async_busy", 32'(busy), 32'(0));
        check("rr_async_addr", 32'(reg_addr), 32'(0));
        wait_clk(2);
        rst = 1'b0;
        m_sda = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        bus_start;
        pending_hit++;
        write_byte(8'hA0, a); check("rr_next_ack", 32'(a), 32'(0));
        write_byte(8'h07, a); check("rr_next_ptr_ack", 32'(a), 32'(0));
        q_we.push_back({8'h07, 8'h99});
        write_byte(8'h99, a); check("rr_next_data_ack", 32'(a), 32'(0));
        bus_stop;
        wait_clk(Q);
        check("rr_next_addr", 32'(reg_addr), 32'(8'h08));

        // Every expected strobe must have been observed
        wait_clk(20);
        check("we_queue_drained", 32'(q_we.size()), 32'(0));
        check("re_queue_drained", 32'(q_re.size()), 32'(0));
        check("hit_count_drained", 32'(pending_hit), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
